// File: rtl/addsub_nbits_seq.sv
// Multi-cycle signed add/sub with start/done handshake and overflow/carry flags.
// Define SEC_ADDSUB_SATURATE_EN to saturate on overflow instead of returning zero.
module addsub_nbits_seq #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             cout
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             v;
  logic [WIDTH-1:0] res_nxt;

  // Subtraction as a + ~b + 1, all from the latched operands.
  always_comb begin
    bb = op_q ? ~b_q : b_q;
    {carry, sum} = {1'b0, a_q} + {1'b0, bb}
                 + {{WIDTH{1'b0}}, op_q};
    v = (a_q[MSB] == bb[MSB]) && (sum[MSB] != a_q[MSB]);
    res_nxt = sum;
    if (v) begin
`ifdef SEC_ADDSUB_SATURATE_EN
      res_nxt = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
`else
      res_nxt = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      cout   <= 1'b0;
    end else if (start) begin
      // A start in any state aborts whatever is in flight.
      state  <= RUN;
      cnt    <= CW'(1);
      a_q    <= a;
      b_q    <= b;
      op_q   <= op;
      busy   <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
        end
        RUN: begin
          if (cnt == LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_nxt;
            ovf    <= v;
            cout   <= carry;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
